// File: rtl/decode_stage_p.sv
// Decode stage: register file with writeback bypass, instruction decode,
// load-use hazard detection with one-cycle bubble insertion, and a stall counter.
module decode_stage_p #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             EN_REG,
  input  logic             valid_in,
  input  logic [XLEN-1:0]  PCNEXT_init,
  input  logic [31:0]      instruction,
  input  logic [4:0]       registerD,
  input  logic [XLEN-1:0]  registerD_data,
  input  logic             RegW_en,
  output logic             hazard_stall,
  output logic             valid_out,
  output logic [XLEN-1:0]  RegAdata,
  output logic [XLEN-1:0]  RegBdata,
  output logic [XLEN-1:0]  imm_ext,
  output logic [XLEN-1:0]  PCNEXT,
  output logic [4:0]       regA,
  output logic [4:0]       regB,
  output logic [4:0]       regDest,
  output logic [5:0]       FUNCTION,
  output logic [1:0]       ALU_OP,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic             MEM_TO_REG,
  output logic             is_BRANCH,
  output logic             is_immediate,
  output logic             illegal,
  output logic [CNT_W-1:0] hz_count
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rdst;
    logic [5:0]      fn;
    logic [1:0]      alu;
    logic            wb;
    logic            mr;
    logic            mw;
    logic            m2r;
    logic            br;
    logic            imm_sel;
    logic            ill;
  } stage_t;

  logic [XLEN-1:0] rf [NREG];
  stage_t          stage_q;
  stage_t          stage_d;

  logic [5:0]    opcode;
  logic [4:0]    rs_f, rt_f, rd_f;
  logic [AW-1:0] rs_i, rt_i, wd_i, dst_i;
  logic [15:0]   imm16;
  logic          wr_en;
  logic          rt_used;
  logic          sext;
  logic          raw_hazard;

  assign opcode = instruction[31:26];
  assign rs_f   = instruction[25:21];
  assign rt_f   = instruction[20:16];
  assign rd_f   = instruction[15:11];
  assign imm16  = instruction[15:0];
  assign rs_i   = rs_f[AW-1:0];
  assign rt_i   = rt_f[AW-1:0];
  assign wd_i   = registerD[AW-1:0];
  assign dst_i  = stage_q.rdst[AW-1:0];
  assign wr_en  = RegW_en && (wd_i != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wd_i] <= registerD_data;
    end
  end

  always_comb begin
    stage_d       = '0;
    rt_used       = 1'b0;
    sext          = 1'b1;
    stage_d.valid = 1'b1;
    stage_d.pc    = PCNEXT_init;
    stage_d.ra    = rs_f;
    stage_d.rb    = rt_f;
    stage_d.fn    = instruction[5:0];
    case (opcode_e'(opcode))
      OP_RTYPE: begin
        stage_d.wb = 1'b1; stage_d.alu = 2'b10; stage_d.rdst = rd_f; rt_used = 1'b1;
      end
      OP_ADDI: begin
        stage_d.wb = 1'b1; stage_d.imm_sel = 1'b1; stage_d.rdst = rt_f;
      end
      OP_ANDI: begin
        stage_d.wb = 1'b1; stage_d.imm_sel = 1'b1; stage_d.alu = 2'b11;
        stage_d.rdst = rt_f; sext = 1'b0;
      end
      OP_LW: begin
        stage_d.wb = 1'b1; stage_d.mr = 1'b1; stage_d.m2r = 1'b1;
        stage_d.imm_sel = 1'b1; stage_d.rdst = rt_f;
      end
      OP_SW: begin
        stage_d.mw = 1'b1; stage_d.imm_sel = 1'b1; rt_used = 1'b1;
      end
      OP_BEQ: begin
        stage_d.br = 1'b1; stage_d.alu = 2'b01; rt_used = 1'b1;
      end
      default: stage_d.ill = 1'b1;
    endcase
    if (stage_d.rdst[AW-1:0] == '0) stage_d.wb = 1'b0;
    stage_d.imm = sext ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};
    // Same-cycle writeback to the read index wins over the stored value.
    if (rs_i == '0)                  stage_d.a = '0;
    else if (wr_en && wd_i == rs_i)  stage_d.a = registerD_data;
    else                             stage_d.a = rf[rs_i];
    if (rt_i == '0)                  stage_d.b = '0;
    else if (wr_en && wd_i == rt_i)  stage_d.b = registerD_data;
    else                             stage_d.b = rf[rt_i];
  end

  assign raw_hazard = stage_q.valid && stage_q.mr && (dst_i != '0) && valid_in &&
                      ((dst_i == rs_i) || ((dst_i == rt_i) && rt_used));
  assign hazard_stall = raw_hazard && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (EN_REG) begin
      if (hazard_stall || !valid_in) stage_q <= '0;
      else                           stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz_count <= '0;
    end else if (EN_REG && hazard_stall && (hz_count != '1)) begin
      hz_count <= hz_count + 1'b1;
    end
  end

  assign valid_out    = stage_q.valid;
  assign RegAdata     = stage_q.a;
  assign RegBdata     = stage_q.b;
  assign imm_ext      = stage_q.imm;
  assign PCNEXT       = stage_q.pc;
  assign regA         = stage_q.ra;
  assign regB         = stage_q.rb;
  assign regDest      = stage_q.rdst;
  assign FUNCTION     = stage_q.fn;
  assign ALU_OP       = stage_q.alu;
  assign WB_EN        = stage_q.wb;
  assign MEM_R_EN     = stage_q.mr;
  assign MEM_W_EN     = stage_q.mw;
  assign MEM_TO_REG   = stage_q.m2r;
  assign is_BRANCH    = stage_q.br;
  assign is_immediate = stage_q.imm_sel;
  assign illegal      = stage_q.ill;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: table of single-instruction decodes plus
// hand sequences for load-use stalls, hold, flush, bypass and async reset.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        reset, flush, EN_REG, valid_in, RegW_en;
  logic [31:0] PCNEXT_init, instruction, registerD_data;
  logic [4:0]  registerD;
  logic        hazard_stall, valid_out;
  logic [31:0] RegAdata, RegBdata, imm_ext, PCNEXT;
  logic [4:0]  regA, regB, regDest;
  logic [5:0]  FUNCTION;
  logic [1:0]  ALU_OP;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG, is_BRANCH, is_immediate, illegal;
  logic [15:0] hz_count;

  int checks   = 0;
  int failures = 0;
  int exp_hz   = 0;

  decode_stage_p #(.XLEN(32), .NREG(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .EN_REG(EN_REG), .valid_in(valid_in),
    .PCNEXT_init(PCNEXT_init), .instruction(instruction), .registerD(registerD),
    .registerD_data(registerD_data), .RegW_en(RegW_en), .hazard_stall(hazard_stall),
    .valid_out(valid_out), .RegAdata(RegAdata), .RegBdata(RegBdata), .imm_ext(imm_ext),
    .PCNEXT(PCNEXT), .regA(regA), .regB(regB), .regDest(regDest), .FUNCTION(FUNCTION),
    .ALU_OP(ALU_OP), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .MEM_TO_REG(MEM_TO_REG), .is_BRANCH(is_BRANCH), .is_immediate(is_immediate),
    .illegal(illegal), .hz_count(hz_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        hz;
    logic [8:0]  ctrl;   // wb,mr,mw,m2r,br,imm,alu[1:0],illegal
    logic [4:0]  dest;
    logic        chk_ab;
    logic        chk_imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] immx;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [8:0] ctrl_now();
    return {WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG, is_BRANCH, is_immediate, ALU_OP, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    instruction = ins;
    valid_in    = 1'b1;
    step();
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_ctrl"}, {23'd0, ctrl_now()}, 32'd0);
    chk({tag, "_dest"}, {27'd0, regDest}, 32'd0);
    chk({tag, "_hz"}, {16'd0, hz_count}, exp_hz);
  endtask

  initial begin
    vecs[0] = '{rtype(5, 0, 3, 6'h20), 1'b0, 9'b1_0_0_0_0_0_10_0, 5'd3, 1'b1, 1'b0, 32'h1234, 32'h0, 32'h0};
    vecs[1] = '{itype(6'h08, 1, 2, 16'hFFFC), 1'b0, 9'b1_0_0_0_0_1_00_0, 5'd2, 1'b1, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFFC};
    vecs[2] = '{itype(6'h0C, 1, 2, 16'hFFFC), 1'b0, 9'b1_0_0_0_0_1_11_0, 5'd2, 1'b1, 1'b1, 32'h11, 32'h0, 32'h0000_FFFC};
    vecs[3] = '{itype(6'h2B, 1, 4, 16'h0008), 1'b0, 9'b0_0_1_0_0_1_00_0, 5'd0, 1'b1, 1'b1, 32'h11, 32'h44, 32'h8};
    vecs[4] = '{itype(6'h04, 1, 4, 16'hFFFF), 1'b0, 9'b0_0_0_0_1_0_01_0, 5'd0, 1'b1, 1'b1, 32'h11, 32'h44, 32'hFFFF_FFFF};
    vecs[5] = '{itype(6'h3F, 1, 4, 16'h1234), 1'b0, 9'b0_0_0_0_0_0_00_1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{rtype(1, 4, 0, 6'h20), 1'b0, 9'b0_0_0_0_0_0_10_0, 5'd0, 1'b1, 1'b0, 32'h11, 32'h44, 32'h0};
    vecs[7] = '{itype(6'h23, 1, 4, 16'h0004), 1'b0, 9'b1_1_0_1_0_1_00_0, 5'd4, 1'b1, 1'b1, 32'h11, 32'h44, 32'h4};
    vecs[8] = '{itype(6'h08, 0, 4, 16'h0007), 1'b0, 9'b1_0_0_0_0_1_00_0, 5'd4, 1'b1, 1'b1, 32'h0, 32'h44, 32'h7};
    vecs[9] = '{itype(6'h08, 1, 7, 16'hFFFF), 1'b0, 9'b1_0_0_0_0_1_00_0, 5'd7, 1'b1, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFFF};

    reset = 1'b1; flush = 1'b0; EN_REG = 1'b1; valid_in = 1'b0; RegW_en = 1'b0;
    PCNEXT_init = '0; instruction = '0; registerD = '0; registerD_data = '0;
    #12;
    check_bubble("reset");
    chk("reset_A", RegAdata, 32'h0);
    chk("reset_stall", {31'd0, hazard_stall}, 32'd0);
    reset = 1'b0;

    // Preload r1, r4, r5 through the writeback port with no instruction issued.
    RegW_en = 1'b1;
    registerD = 5'd1; registerD_data = 32'h11;   step();
    registerD = 5'd4; registerD_data = 32'h44;   step();
    registerD = 5'd5; registerD_data = 32'h1234; step();
    RegW_en = 1'b0;
    chk("preload_bubble", {31'd0, valid_out}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      instruction = vecs[i].instr;
      valid_in    = 1'b1;
      PCNEXT_init = 32'h100 + 32'(4 * i);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, hazard_stall}, {31'd0, vecs[i].hz});
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, valid_out}, 32'd1);
      chk($sformatf("v%0d_ctrl", i), {23'd0, ctrl_now()}, {23'd0, vecs[i].ctrl});
      chk($sformatf("v%0d_dest", i), {27'd0, regDest}, {27'd0, vecs[i].dest});
      chk($sformatf("v%0d_regs", i), {22'd0, regA, regB}, {22'd0, vecs[i].instr[25:16]});
      chk($sformatf("v%0d_fn", i), {26'd0, FUNCTION}, {26'd0, vecs[i].instr[5:0]});
      chk($sformatf("v%0d_pc", i), PCNEXT, 32'h100 + 32'(4 * i));
      if (vecs[i].chk_ab) begin
        chk($sformatf("v%0d_A", i), RegAdata, vecs[i].a);
        chk($sformatf("v%0d_B", i), RegBdata, vecs[i].b);
      end
      if (vecs[i].chk_imm) chk($sformatf("v%0d_imm", i), imm_ext, vecs[i].immx);
    end

    // Load-use with an R-type consumer: one bubble, then issue.
    issue(itype(6'h23, 1, 4, 16'h0));
    instruction = rtype(4, 1, 6, 6'h20);
    #1;
    chk("lu_stall", {31'd0, hazard_stall}, 32'd1);
    step();
    exp_hz++;
    check_bubble("lu_bubble");
    chk("lu_stall_drop", {31'd0, hazard_stall}, 32'd0);
    step();
    chk("lu_issue_valid", {31'd0, valid_out}, 32'd1);
    chk("lu_issue_dest", {27'd0, regDest}, 32'd6);
    chk("lu_issue_A", RegAdata, 32'h44);
    chk("lu_issue_B", RegBdata, 32'h11);
    chk("lu_issue_hz", {16'd0, hz_count}, exp_hz);

    // Store reading the loaded register through rt also stalls.
    issue(itype(6'h23, 1, 4, 16'h0));
    instruction = itype(6'h2B, 1, 4, 16'h0);
    #1;
    chk("sw_stall", {31'd0, hazard_stall}, 32'd1);
    step();
    exp_hz++;
    check_bubble("sw_bubble");
    step();
    chk("sw_issue", {30'd0, valid_out, MEM_W_EN}, 32'd3);

    // Downstream hold during the hazard: LW stays, no bubble, no count.
    issue(itype(6'h23, 1, 4, 16'h0));
    instruction = rtype(4, 1, 6, 6'h20);
    EN_REG = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_stall", c), {31'd0, hazard_stall}, 32'd1);
      step();
      chk($sformatf("hold%0d_lw", c), {25'd0, valid_out, MEM_R_EN, regDest}, {25'd0, 2'b11, 5'd4});
      chk($sformatf("hold%0d_hz", c), {16'd0, hz_count}, exp_hz);
    end
    EN_REG = 1'b1;
    step();
    exp_hz++;
    check_bubble("hold_release");
    step();
    chk("hold_issue", {26'd0, valid_out, regDest}, {26'd0, 1'b1, 5'd6});

    // Flush coinciding with a hazard: bubble, stall suppressed, no count.
    issue(itype(6'h23, 1, 4, 16'h0));
    instruction = rtype(4, 1, 6, 6'h20);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    check_bubble("flush_bubble");
    flush = 1'b0;
    step();
    chk("flush_issue", {26'd0, valid_out, regDest}, {26'd0, 1'b1, 5'd6});
    chk("flush_hz", {16'd0, hz_count}, exp_hz);

    // Same-cycle writeback bypass, then the stored value; r0 writes ignored.
    RegW_en = 1'b1; registerD = 5'd9; registerD_data = 32'hAA;
    issue(rtype(9, 0, 1, 6'h20));
    chk("byp_A", RegAdata, 32'hAA);
    RegW_en = 1'b0;
    issue(rtype(0, 9, 1, 6'h20));
    chk("rf_B", RegBdata, 32'hAA);
    RegW_en = 1'b1; registerD = 5'd0; registerD_data = 32'h55;
    issue(rtype(0, 0, 1, 6'h20));
    chk("r0_byp", {RegAdata[15:0], RegBdata[15:0]}, 32'h0);
    RegW_en = 1'b0;
    issue(rtype(0, 0, 1, 6'h20));
    chk("r0_read", RegAdata, 32'h0);

    // Async reset in the middle of a stall.
    issue(itype(6'h23, 1, 4, 16'h0));
    instruction = rtype(4, 1, 6, 6'h20);
    #1;
    chk("rst_pre_stall", {31'd0, hazard_stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    exp_hz = 0;
    check_bubble("rst_async");
    chk("rst_stall", {31'd0, hazard_stall}, 32'd0);
    chk("rst_A", RegAdata, 32'h0);
    #1 reset = 1'b0;
    step();
    chk("rst_rf_valid", {31'd0, valid_out}, 32'd1);
    chk("rst_rf_cleared", {RegAdata[15:0], RegBdata[15:0]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
